mbox_cyc: RTL and testbench

MBOX_CYC -- requirements
Module: mbox_cyc

---
 rtl/ebox_pkg.sv | 6 +
 rtl/mbox_nxm_timer.sv | 20 ++
 rtl/mbox_cyc.sv | 106 ++++++++++
 tb/tb_mbox_cyc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ebox_pkg.sv
// ebox_pkg: shared EBOX definitions for the MBOX cycle controller.
// Provides the controller state type and the non-existent-memory timeout limit.
package ebox_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RDWAIT, S_PAUSE, S_WREQ} mbox_state_e;
  localparam logic [7:0] NXM_LIMIT = 8'd255;
endpackage

// File: rtl/mbox_nxm_timer.sv
// mbox_nxm_timer: counts MBOX waiting cycles and flags a non-existent-memory timeout.
// Ports: clk, RESET_n (async, active low), clr_i (restart at 0), en_i (a waiting
// cycle), expire_o (this waiting cycle is the NXM_LIMIT-th one).
module mbox_nxm_timer
  import ebox_pkg::*;
(
  input  logic clk,
  input  logic RESET_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge RESET_n)
    if (!RESET_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  // cnt_q holds the waiting cycles already spent, so the limit is hit during the last one
  assign expire_o = en_i & (cnt_q == NXM_LIMIT - 8'd1);
endmodule

// File: rtl/mbox_cyc.sv
// mbox_cyc: EBOX-side MBOX cycle controller (read, write and read-pause-write).
// Inputs: CYC_REQ pulse with cycle type VMA_*, address VMA and store data AR;
// MBOX handshake MB_ACK/MB_PF/MB_RD_VALID/MB_RD_DATA; ERR_CLR for sticky errors.
// Outputs: MBOX request MB_REQ/MB_RD/MB_WR/MB_LOCK/MB_ADR/MB_WDATA, returned word
// EBOX_DATA with DATA_VALID strobe, MB_WAIT/BUSY status, sticky PF_HOLD/NXM_ERR/OVERRUN_ERR.
module mbox_cyc
  import ebox_pkg::*;
(
  input  logic         clk,
  input  logic         RESET_n,
  input  logic         CYC_REQ,
  input  logic         VMA_READ,
  input  logic         VMA_WRITE,
  input  logic         VMA_PAUSE,
  input  logic         VMA_FETCH,
  input  logic [13:35] VMA,
  input  logic [0:35]  AR,
  input  logic         MB_ACK,
  input  logic         MB_RD_VALID,
  input  logic [0:35]  MB_RD_DATA,
  input  logic         MB_PF,
  input  logic         ERR_CLR,
  output logic         MB_REQ,
  output logic         MB_RD,
  output logic         MB_WR,
  output logic         MB_LOCK,
  output logic [13:35] MB_ADR,
  output logic [0:35]  MB_WDATA,
  output logic [0:35]  EBOX_DATA,
  output logic         DATA_VALID,
  output logic         MB_WAIT,
  output logic         BUSY,
  output logic         PF_HOLD,
  output logic         NXM_ERR,
  output logic         OVERRUN_ERR
);
  mbox_state_e  state_q, state_d;
  logic [13:35] vma_q;
  logic [0:35]  ar_q, data_q;
  logic rd_q, wr_q, pause_q, dv_q, pf_q, nxm_q, ovr_q;
  logic accept, in_req, ack_ok, ack_pf, rd_done, waiting, expire, tmr_clr;
  // a write in PAUSE completes the read-pause-write; anything else outside IDLE is an overrun
  assign accept  = RESET_n & CYC_REQ & (state_q == S_IDLE | (state_q == S_PAUSE & VMA_WRITE));
  assign in_req  = state_q == S_REQ | state_q == S_WREQ;
  assign ack_ok  = in_req & MB_ACK & ~MB_PF;
  assign ack_pf  = in_req & MB_ACK & MB_PF;
  assign rd_done = state_q == S_RDWAIT & MB_RD_VALID;
  assign waiting = (in_req & ~MB_ACK) | (state_q == S_RDWAIT & ~MB_RD_VALID);
  always_comb begin
    state_d = state_q;
    if (accept) state_d = (state_q == S_PAUSE) ? S_WREQ : S_REQ;
    else if (expire | ack_pf) state_d = S_IDLE;
    else if (ack_ok) state_d = (state_q == S_REQ && rd_q) ? S_RDWAIT : S_IDLE;
    else if (rd_done) state_d = pause_q ? S_PAUSE : S_IDLE;
  end
  assign tmr_clr = (state_d != state_q) && (state_d inside {S_REQ, S_RDWAIT, S_WREQ});
  mbox_nxm_timer u_tmr (
    .clk      (clk),
    .RESET_n  (RESET_n),
    .clr_i    (tmr_clr),
    .en_i     (waiting),
    .expire_o (expire)
  );
  always_ff @(posedge clk or negedge RESET_n)
    if (!RESET_n) begin
      state_q <= S_IDLE;
      vma_q   <= '0;
      ar_q    <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pause_q <= 1'b0;
      dv_q    <= 1'b0;
      pf_q    <= 1'b0;
      nxm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // the write half of an RPW keeps the address and type captured by the read
      if (accept && state_q == S_IDLE) begin
        vma_q   <= VMA;
        rd_q    <= VMA_READ | VMA_FETCH;
        wr_q    <= VMA_WRITE & ~VMA_PAUSE;
        pause_q <= VMA_PAUSE;
      end
      if (accept && VMA_WRITE) ar_q <= AR;
      if (rd_done) data_q <= MB_RD_DATA;
      dv_q  <= rd_done;
      pf_q  <= ack_pf | (pf_q & ~ERR_CLR);
      nxm_q <= expire | (nxm_q & ~ERR_CLR);
      ovr_q <= (CYC_REQ & ~accept) | (ovr_q & ~ERR_CLR);
    end
  assign MB_REQ      = in_req;
  assign MB_RD       = state_q == S_REQ & rd_q;
  assign MB_WR       = (state_q == S_REQ) ? wr_q : state_q == S_WREQ;
  assign MB_LOCK     = state_q == S_WREQ | (pause_q & rd_q & state_q inside {S_REQ, S_RDWAIT, S_PAUSE});
  assign MB_ADR      = vma_q;
  assign MB_WDATA    = ar_q;
  assign EBOX_DATA   = data_q;
  assign DATA_VALID  = dv_q;
  assign MB_WAIT     = (state_q inside {S_REQ, S_RDWAIT, S_WREQ}) | accept;
  assign BUSY        = state_q != S_IDLE;
  assign PF_HOLD     = pf_q;
  assign NXM_ERR     = nxm_q;
  assign OVERRUN_ERR = ovr_q;
endmodule

// File: tb/tb_mbox_cyc.sv
// tb_mbox_cyc: directed bench for mbox_cyc with a DATA_VALID scoreboard.
module tb_mbox_cyc;
  logic clk = 1'b0;
  logic RESET_n = 1'b0;
  logic CYC_REQ = 0, VMA_READ = 0, VMA_WRITE = 0, VMA_PAUSE = 0, VMA_FETCH = 0;
  logic [13:35] VMA = '0;
  logic [0:35] AR = '0, MB_RD_DATA = '0;
  logic MB_ACK = 0, MB_RD_VALID = 0, MB_PF = 0, ERR_CLR = 0;
  logic MB_REQ, MB_RD, MB_WR, MB_LOCK, DATA_VALID, MB_WAIT, BUSY, PF_HOLD, NXM_ERR, OVERRUN_ERR;
  logic [13:35] MB_ADR;
  logic [0:35] MB_WDATA, EBOX_DATA;
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  typedef struct {logic [35:0] d; int due;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mbox_cyc dut (
    .clk(clk), .RESET_n(RESET_n), .CYC_REQ(CYC_REQ),
    .VMA_READ(VMA_READ), .VMA_WRITE(VMA_WRITE), .VMA_PAUSE(VMA_PAUSE), .VMA_FETCH(VMA_FETCH),
    .VMA(VMA), .AR(AR), .MB_ACK(MB_ACK), .MB_RD_VALID(MB_RD_VALID), .MB_RD_DATA(MB_RD_DATA),
    .MB_PF(MB_PF), .ERR_CLR(ERR_CLR), .MB_REQ(MB_REQ), .MB_RD(MB_RD), .MB_WR(MB_WR),
    .MB_LOCK(MB_LOCK), .MB_ADR(MB_ADR), .MB_WDATA(MB_WDATA), .EBOX_DATA(EBOX_DATA),
    .DATA_VALID(DATA_VALID), .MB_WAIT(MB_WAIT), .BUSY(BUSY), .PF_HOLD(PF_HOLD),
    .NXM_ERR(NXM_ERR), .OVERRUN_ERR(OVERRUN_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
    $fatal(1);
  end

  // scoreboard monitor: every DATA_VALID strobe must match the oldest expected word and cycle
  always @(negedge clk)
    if (DATA_VALID) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: DATA_VALID with data %0o, expected no strobe", EBOX_DATA);
      end else begin
        mon_e = sb.pop_front();
        if (EBOX_DATA !== mon_e.d || cyc_n != mon_e.due) begin
          n_fail++;
          $display("FAIL sb_data: got %0o at cycle %0d, expected %0o at cycle %0d",
                   EBOX_DATA, cyc_n, mon_e.d, mon_e.due);
        end
      end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    CYC_REQ = 0; VMA_READ = 0; VMA_WRITE = 0; VMA_PAUSE = 0; VMA_FETCH = 0; VMA = '0; AR = '0;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_ctl"}, {MB_REQ, MB_RD, MB_WR, MB_LOCK, DATA_VALID, MB_WAIT, BUSY,
                       PF_HOLD, NXM_ERR, OVERRUN_ERR}, 0);
    chk({nm, "_adr"}, MB_ADR, 0);
    chk({nm, "_wdata"}, MB_WDATA, 0);
    chk({nm, "_data"}, EBOX_DATA, 0);
  endtask

  // zero-wait read: ack in REQ's first cycle, data in RDWAIT's first cycle; ends in the DATA_VALID cycle
  task automatic do_read(input logic [22:0] a, input logic [35:0] d, input logic pause);
    int c0;
    step();
    CYC_REQ = 1; VMA_READ = 1; VMA_PAUSE = pause; VMA = a; c0 = cyc_n;
    #1 chk("rd_accept_wait", MB_WAIT, 1);
    step();
    idle_in();
    chk("rd_req", {MB_REQ, MB_RD, MB_WR, MB_LOCK}, {3'b110, pause});
    chk("rd_adr", MB_ADR, a);
    MB_ACK = 1;
    step();
    MB_ACK = 0;
    chk("rdwait_req", {MB_REQ, MB_WAIT, MB_LOCK}, {2'b01, pause});
    MB_RD_VALID = 1; MB_RD_DATA = d;
    sb.push_back('{d, c0 + 3});
    step();
    MB_RD_VALID = 0; MB_RD_DATA = '0;
  endtask

  initial begin
    int c0, n;
    logic early;
    repeat (2) step();
    all_zero("reset");
    @(negedge clk) RESET_n = 1;

    // plain read
    do_read(23'o1000, 36'o123456654321, 1'b0);
    chk("read_done", {MB_WAIT, BUSY}, 0);
    step();
    chk("read_dv_once", DATA_VALID, 0);
    chk("read_data_held", EBOX_DATA, 36'o123456654321);

    // read-pause-write
    do_read(23'o1000, 36'o777, 1'b1);
    chk("pause_state", {MB_LOCK, BUSY, MB_WAIT, MB_REQ}, 4'b1100);
    step();
    chk("pause_lock", MB_LOCK, 1);
    step();
    CYC_REQ = 1; VMA_WRITE = 1; VMA = 23'o2000; AR = 36'o7;
    #1 chk("wreq_accept_wait", MB_WAIT, 1);
    step();
    idle_in();
    chk("wreq_ctl", {MB_REQ, MB_RD, MB_WR, MB_LOCK}, 4'b1011);
    chk("wreq_adr", MB_ADR, 23'o1000);
    chk("wreq_wdata", MB_WDATA, 36'o7);
    step();
    MB_ACK = 1;
    #1 chk("wreq_lock_at_ack", MB_LOCK, 1);
    step();
    MB_ACK = 0;
    chk("rpw_done", {MB_LOCK, BUSY, MB_REQ}, 0);

    // page failure
    step();
    CYC_REQ = 1; VMA_READ = 1; VMA = 23'o3000;
    step();
    idle_in();
    MB_ACK = 1; MB_PF = 1;
    step();
    MB_ACK = 0; MB_PF = 0;
    chk("pf_set", {PF_HOLD, BUSY, MB_REQ}, 3'b100);
    step();
    chk("pf_no_dv", {DATA_VALID, PF_HOLD}, 2'b01);
    ERR_CLR = 1;
    step();
    ERR_CLR = 0;
    chk("pf_clr", PF_HOLD, 0);

    // overrun in RDWAIT, with ERR_CLR in the same cycle as the set
    step();
    CYC_REQ = 1; VMA_READ = 1; VMA = 23'o4000; c0 = cyc_n;
    step();
    idle_in();
    MB_ACK = 1;
    step();
    MB_ACK = 0;
    CYC_REQ = 1; VMA_READ = 1; VMA = 23'o5000; ERR_CLR = 1;
    step();
    idle_in();
    ERR_CLR = 0;
    chk("ovr_set", {OVERRUN_ERR, BUSY}, 2'b11);
    chk("ovr_adr_kept", MB_ADR, 23'o4000);
    MB_RD_VALID = 1; MB_RD_DATA = 36'o11;
    sb.push_back('{36'o11, c0 + 4});
    step();
    MB_RD_VALID = 0; MB_RD_DATA = '0;
    chk("ovr_read_done", {BUSY, OVERRUN_ERR}, 2'b01);
    ERR_CLR = 1;
    step();
    ERR_CLR = 0;
    chk("ovr_clr", OVERRUN_ERR, 0);

    // pure write
    step();
    CYC_REQ = 1; VMA_WRITE = 1; VMA = 23'o6000; AR = 36'o123;
    step();
    idle_in();
    chk("wr_ctl", {MB_REQ, MB_RD, MB_WR, MB_LOCK}, 4'b1010);
    chk("wr_adr", MB_ADR, 23'o6000);
    chk("wr_wdata", MB_WDATA, 36'o123);
    MB_ACK = 1;
    step();
    MB_ACK = 0;
    chk("wr_done", {BUSY, MB_WAIT}, 0);

    // NXM timeout: no ack ever
    step();
    CYC_REQ = 1; VMA_READ = 1; VMA = 23'o7000;
    step();
    idle_in();
    n = 0; early = 0;
    while (MB_REQ && n < 300) begin
      if (NXM_ERR) early = 1;
      n++;
      step();
    end
    chk("nxm_req_cycles", n, 255);
    chk("nxm_not_early", early, 0);
    chk("nxm_set", {NXM_ERR, MB_REQ, MB_LOCK, BUSY}, 4'b1000);

    // asynchronous reset while an RPW is parked in PAUSE
    do_read(23'o1000, 36'o55, 1'b1);
    step();
    chk("pre_reset", {MB_LOCK, BUSY, NXM_ERR}, 3'b111);
    #2 RESET_n = 0;
    #1 all_zero("async_reset");
    @(negedge clk) RESET_n = 1;

    // recovery read
    do_read(23'o1234, 36'o42, 1'b0);
    step();
    chk("recover_idle", BUSY, 0);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
